// File: rtl/vga_timing_gen_if.sv
// Bundle of the pixel-advance enable and all timing outputs of vga_timing_gen.
// The slave side is the timing generator; the master side is whoever paces pixels.
interface vga_timing_gen_if #(
  parameter int unsigned CNT_W = 16
);
  logic             pix_en;
  logic [CNT_W-1:0] H_count_value;
  logic [CNT_W-1:0] V_count_value;
  logic             hsync;
  logic             vsync;
  logic             video_on;
  logic             line_end;
  logic             frame_end;

  modport master (
    output pix_en,
    input  H_count_value, V_count_value, hsync, vsync, video_on, line_end, frame_end
  );

  modport slave (
    input  pix_en,
    output H_count_value, V_count_value, hsync, vsync, video_on, line_end, frame_end
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: horizontal/vertical counters with registered sync and blanking
// outputs that are aligned to the counters, plus combinational end-of-line/frame pulses.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             CLK25MHZ,
  input  logic             RESETN,
  vga_timing_gen_if.slave  vga
);

  localparam longint unsigned H_TOTAL = longint'(H_ACTIVE) + H_FP + H_SYNC + H_BP;
  localparam longint unsigned V_TOTAL = longint'(V_ACTIVE) + V_FP + V_SYNC + V_BP;
  localparam longint unsigned CNT_SPAN = longint'(1) << CNT_W;

  generate
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_width
      $error("vga_timing_gen: CNT_W must be within 1..32");
    end
    if (H_TOTAL > CNT_SPAN || V_TOTAL > CNT_SPAN) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
    end
    if (H_SYNC == 0 || V_SYNC == 0 || H_ACTIVE == 0 || V_ACTIVE == 0) begin : g_bad_geom
      $error("vga_timing_gen: active and sync widths must be non-zero");
    end
  endgenerate

  localparam logic [CNT_W-1:0] H_MAX      = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_MAX      = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  function automatic logic hsync_level(input logic [CNT_W-1:0] h);
    return ((h >= HS_FIRST) && (h <= HS_LAST)) ? HS_POL : ~HS_POL;
  endfunction

  function automatic logic vsync_level(input logic [CNT_W-1:0] v);
    return ((v >= VS_FIRST) && (v <= VS_LAST)) ? VS_POL : ~VS_POL;
  endfunction

  function automatic logic active_level(input logic [CNT_W-1:0] h,
                                        input logic [CNT_W-1:0] v);
    return (h < H_ACT_END) && (v < V_ACT_END);
  endfunction

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_video_on;

  logic             w_h_last;
  logic             w_v_last;
  logic [CNT_W-1:0] w_h_nxt;
  logic [CNT_W-1:0] w_v_nxt;

  // Next-position decode; wraps are explicit so counters can never exceed the totals.
  always_comb begin
    w_h_last = (r_h_cnt == H_MAX);
    w_v_last = (r_v_cnt == V_MAX);
    w_h_nxt  = w_h_last ? '0 : r_h_cnt + CNT_W'(1);
    w_v_nxt  = r_v_cnt;
    if (w_h_last) begin
      w_v_nxt = w_v_last ? '0 : r_v_cnt + CNT_W'(1);
    end
  end

  // Sync and blanking are decoded from the next position so they land with the counters.
  always_ff @(posedge CLK25MHZ or negedge RESETN) begin
    if (!RESETN) begin
      r_h_cnt    <= '0;
      r_v_cnt    <= '0;
      r_hsync    <= ~HS_POL;
      r_vsync    <= ~VS_POL;
      r_video_on <= 1'b1;
    end else if (vga.pix_en) begin
      r_h_cnt    <= w_h_nxt;
      r_v_cnt    <= w_v_nxt;
      r_hsync    <= hsync_level(w_h_nxt);
      r_vsync    <= vsync_level(w_v_nxt);
      r_video_on <= active_level(w_h_nxt, w_v_nxt);
    end
  end

  assign vga.H_count_value = r_h_cnt;
  assign vga.V_count_value = r_v_cnt;
  assign vga.hsync         = r_hsync;
  assign vga.vsync         = r_vsync;
  assign vga.video_on      = r_video_on;
  // Gated by RESETN so the pulses are quiet during reset regardless of geometry.
  assign vga.line_end      = RESETN & vga.pix_en & w_h_last;
  assign vga.frame_end     = RESETN & vga.pix_en & w_h_last & w_v_last;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_FP, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 Parameter V_BP, default 33, vertical back porch in lines.
REQ-009 Parameter HS_POL, default 0, hsync asserted level (0 = active-low).
REQ-010 Parameter VS_POL, default 0, vsync asserted level (0 = active-low).
REQ-011 Parameter CNT_W, default 16, counter and coordinate width.
REQ-012 CLK25MHZ  input  1  pixel clock; the block's only clock.
REQ-013 RESETN  input  1  reset; asynchronous, active-low.
REQ-014 pix_en  input  1  pixel-advance enable; when low, the block holds all state.
REQ-015 H_count_value  output  CNT_W  horizontal position, 0..H_TOTAL-1.
REQ-016 V_count_value  output  CNT_W  vertical position, 0..V_TOTAL-1.
REQ-017 hsync  output  1  horizontal sync at HS_POL level during the sync region.
REQ-018 vsync  output  1  vertical sync at VS_POL level during the sync region.
REQ-019 video_on  output  1  high when both counters are in the active region.
REQ-020 line_end  output  1  one-cycle pulse when H_count_value = H_TOTAL-1 and pix_en = 1.
REQ-021 frame_end  output  1  one-cycle pulse when both counters are at their maximum and pix_en = 1.

Function
REQ-022 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; both SHALL fit in CNT_W bits (elaboration-time check).
REQ-023 On a rising edge with pix_en = 1, H_count_value SHALL increment by 1 and wrap from H_TOTAL-1 to 0.
REQ-024 V_count_value SHALL increment only on the edge where H wraps, and SHALL wrap from V_TOTAL-1 to 0 on that same edge.
REQ-025 With pix_en = 0, the counters and the hsync, vsync and video_on outputs SHALL hold; line_end and frame_end SHALL be 0.
REQ-026 hsync SHALL equal HS_POL while H is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], and ~HS_POL otherwise.
REQ-027 vsync SHALL equal VS_POL while V is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], and ~VS_POL otherwise; it depends on V only.
REQ-028 hsync, vsync and video_on SHALL be registered and always reflect the counter values presented in the same cycle, with zero skew to the counters.
REQ-029 line_end and frame_end SHALL be combinational decodes of the current counters ANDed with pix_en.
REQ-030 frame_end SHALL imply line_end in the same cycle.
REQ-031 Counters SHALL never hold a value of H_TOTAL or above, or V_TOTAL or above.

Reset
REQ-032 RESETN low SHALL immediately, without a clock edge, force the following outputs:
- counters = 0;
- video_on = 1;
- hsync = ~HS_POL;
- vsync = ~VS_POL.
REQ-033 line_end and frame_end SHALL be 0 while RESETN is low.
REQ-034 On the first pix_en edge after RESETN deasserts, H SHALL go to 1; an assertion mid-frame SHALL restart at (0,0) with no partial line carried over.

Verification
REQ-035 Defaults, pix_en = 1: H from 0 to 799 then wraps. Required response:
- hsync is 0 exactly for H 656..751;
- video_on is 0 for H 640..799;
- line_end fires every 800 cycles.
REQ-036 Defaults: vsync is 0 exactly for V 490..491; frame_end fires at (799,524), then the counters read (0,0) the next cycle; frame period is 420000 cycles.
REQ-037 pix_en toggled 1,0,0,1 starting at H = 10. Required response:
- H reads 11, 11, 11, 12;
- no pulses during the hold cycles;
- sync and video_on outputs unchanged during the hold cycles.
REQ-038 Override H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1, HS_POL=1. Required response:
- hsync is 1 at H 5..6;
- H_TOTAL = 8 and V_TOTAL = 5;
- frame_end at (7,4).
REQ-039 RESETN pulsed low at (300,200) between clock edges: outputs reach their reset values before the next edge, and after release the count resumes 0,1,2 on V = 0.
REQ-040 Random pix_en over 3 frames: checker confirms at every cycle that REQ-026 to REQ-031 hold against a reference model.
